// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch redirect controller: FSM states, redirect
// sources and the sequential PC increment.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RECOVER = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_PRED  = 2'd1,
    SRC_JUMP  = 2'd2,
    SRC_FLUSH = 2'd3
  } src_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Arbitrates flush / jump / BTB-prediction redirects into fetch, parks a
// redirect that arrives during a stall, and masks predictions after a flush.
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int RECOVER_CYCLES = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush_req,
  input  logic [31:0]      correct_pc,
  input  logic             jump_req,
  input  logic [31:0]      jump_target,
  input  logic             predict_taken,
  input  logic             target_valid,
  input  logic [31:0]      predict_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             pc_hold,
  output logic             kill_ifid,
  output logic             kill_idex,
  output logic             busy,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] jump_count,
  output logic [CNT_W-1:0] pred_count
);

  state_e      state_q, state_d;
  src_e        pend_src_q, pend_src_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [3:0]  rec_cnt_q, rec_cnt_d;
  logic        pred_v;
  logic        flush_inc, jump_inc, pred_inc;

  always_comb begin
    state_d        = state_q;
    pend_src_d     = pend_src_q;
    pend_pc_d      = pend_pc_q;
    rec_cnt_d      = rec_cnt_q;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    kill_ifid      = 1'b0;
    kill_idex      = 1'b0;
    flush_inc      = 1'b0;
    jump_inc       = 1'b0;
    pred_inc       = 1'b0;
    pred_v         = predict_taken & target_valid & (state_q != RECOVER);
    pc_hold        = stall & ~flush_req;
    busy           = (state_q != IDLE);

    if (flush_req) begin
      redirect_valid = 1'b1;
      redirect_pc    = correct_pc;
      kill_ifid      = 1'b1;
      kill_idex      = 1'b1;
      flush_inc      = 1'b1;
      pend_src_d     = SRC_NONE;
      rec_cnt_d      = 4'(RECOVER_CYCLES);
      state_d        = RECOVER;
    end else if (state_q == HOLD) begin
      if (stall) begin
        // A jump outranks a parked prediction; a prediction never displaces a jump.
        if (jump_req) begin
          pend_src_d = SRC_JUMP;
          pend_pc_d  = jump_target;
        end else if (pred_v && (pend_src_q == SRC_PRED)) begin
          pend_pc_d = predict_target;
        end
      end else begin
        redirect_valid = 1'b1;
        redirect_pc    = pend_pc_q;
        if (pend_src_q == SRC_JUMP) begin
          kill_ifid = 1'b1;
          jump_inc  = 1'b1;
        end else begin
          pred_inc = 1'b1;
        end
        pend_src_d = SRC_NONE;
        state_d    = IDLE;
      end
    end else begin
      if (state_q == RECOVER) begin
        if (rec_cnt_q != 4'd0) rec_cnt_d = rec_cnt_q - 4'd1;
        state_d = (rec_cnt_q <= 4'd1) ? IDLE : RECOVER;
      end
      if (jump_req || pred_v) begin
        if (stall) begin
          pend_src_d = jump_req ? SRC_JUMP : SRC_PRED;
          pend_pc_d  = jump_req ? jump_target : predict_target;
          state_d    = HOLD;
        end else if (jump_req) begin
          redirect_valid = 1'b1;
          redirect_pc    = jump_target;
          kill_ifid      = 1'b1;
          jump_inc       = 1'b1;
        end else begin
          redirect_valid = 1'b1;
          redirect_pc    = predict_target;
          pred_inc       = 1'b1;
        end
      end
    end

    // Nothing leaves the block while reset is held, whatever the inputs.
    if (reset) begin
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      kill_ifid      = 1'b0;
      kill_idex      = 1'b0;
      pc_hold        = 1'b0;
      busy           = 1'b0;
      flush_inc      = 1'b0;
      jump_inc       = 1'b0;
      pred_inc       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_src_q <= SRC_NONE;
      pend_pc_q  <= '0;
      rec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_src_q <= pend_src_d;
      pend_pc_q  <= pend_pc_d;
      rec_cnt_q  <= rec_cnt_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clock(clock), .reset(reset), .inc(flush_inc), .count(flush_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_jump_cnt (
    .clock(clock), .reset(reset), .inc(jump_inc), .count(jump_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_pred_cnt (
    .clock(clock), .reset(reset), .inc(pred_inc), .count(pred_count)
  );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed scoreboard bench for fetch_redirect_ctrl with a 2-cycle recovery
// window and 4-bit counters so saturation is reachable.
module tb_fetch_redirect_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             stall, flush_req, jump_req, predict_taken, target_valid;
  logic [31:0]      correct_pc, jump_target, predict_target;
  logic             redirect_valid, pc_hold, kill_ifid, kill_idex, busy;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] flush_count, jump_count, pred_count;

  typedef struct {
    string       tag;
    logic        rv;
    logic [31:0] pc;
    logic        ki;
    logic        ke;
    logic        hold;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  fetch_redirect_ctrl #(.RECOVER_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush_req(flush_req),
    .correct_pc(correct_pc), .jump_req(jump_req), .jump_target(jump_target),
    .predict_taken(predict_taken), .target_valid(target_valid),
    .predict_target(predict_target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_hold(pc_hold), .kill_ifid(kill_ifid),
    .kill_idex(kill_idex), .busy(busy), .flush_count(flush_count),
    .jump_count(jump_count), .pred_count(pred_count)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_output();
    exp_t e;
    e = sb.pop_front();
    if (e.rv) check_val({e.tag, ".redirect_pc"}, redirect_pc, e.pc);
    check_val({e.tag, ".redirect_valid"}, 32'(redirect_valid), 32'(e.rv));
    check_val({e.tag, ".kill_ifid"},      32'(kill_ifid),      32'(e.ki));
    check_val({e.tag, ".kill_idex"},      32'(kill_idex),      32'(e.ke));
    check_val({e.tag, ".pc_hold"},        32'(pc_hold),        32'(e.hold));
    check_val({e.tag, ".busy"},           32'(busy),           32'(e.busy));
  endtask

  // Drive one cycle of requests (one shared address for all sources), queue the
  // expected combinational response, check it, then step past the clock edge.
  task automatic apply_stimulus(input string tag, input logic st, fl, jr, pt,
                                input logic [31:0] addr, input logic erv,
                                input logic [31:0] epc, input logic eki, eke, ehold, ebusy);
    exp_t e;
    stall = st; flush_req = fl; jump_req = jr;
    predict_taken = pt; target_valid = pt;
    correct_pc = addr; jump_target = addr; predict_target = addr;
    e.tag = tag; e.rv = erv; e.pc = epc; e.ki = eki; e.ke = eke; e.hold = ehold; e.busy = ebusy;
    sb.push_back(e);
    #2;
    check_output();
    @(posedge clock);
    #1;
  endtask

  task automatic check_counts(input string tag, input int f, input int j, input int p);
    check_val({tag, ".flush_count"}, 32'(flush_count), 32'(f));
    check_val({tag, ".jump_count"},  32'(jump_count),  32'(j));
    check_val({tag, ".pred_count"},  32'(pred_count),  32'(p));
  endtask

  initial begin
    reset = 1'b1;
    stall = 0; flush_req = 0; jump_req = 0; predict_taken = 0; target_valid = 0;
    correct_pc = '0; jump_target = '0; predict_target = '0;
    @(posedge clock);
    #1;
    apply_stimulus("reset", 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    check_counts("reset", 0, 0, 0);
    reset = 1'b0;
    apply_stimulus("post_reset", 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);

    // Unstalled jump issues in the same cycle.
    apply_stimulus("jump", 0, 0, 1, 0, 32'h40, 1, 32'h40, 1, 0, 0, 0);
    check_counts("jump", 0, 1, 0);

    // Prediction parked for three stalled cycles, issued on release.
    apply_stimulus("pstall0", 1, 0, 0, 1, 32'h80, 0, 32'h0, 0, 0, 1, 0);
    apply_stimulus("pstall1", 1, 0, 0, 1, 32'h80, 0, 32'h0, 0, 0, 1, 1);
    apply_stimulus("pstall2", 1, 0, 0, 1, 32'h80, 0, 32'h0, 0, 0, 1, 1);
    apply_stimulus("prel",    0, 0, 0, 0, 32'h0,  1, 32'h80, 0, 0, 0, 1);
    check_counts("prel", 0, 1, 1);

    // Jump displaces a parked prediction; a later prediction cannot displace it.
    apply_stimulus("ovr_pred", 1, 0, 0, 1, 32'h80,  0, 32'h0, 0, 0, 1, 0);
    apply_stimulus("ovr_jump", 1, 0, 1, 0, 32'h100, 0, 32'h0, 0, 0, 1, 1);
    apply_stimulus("ovr_pred2",1, 0, 0, 1, 32'h300, 0, 32'h0, 0, 0, 1, 1);
    apply_stimulus("ovr_rel",  0, 0, 0, 0, 32'h0,   1, 32'h100, 1, 0, 0, 1);
    check_counts("ovr_rel", 0, 2, 1);

    // Flush pre-empts a parked jump, then a 2-cycle prediction blackout.
    apply_stimulus("fl_park",  1, 0, 1, 0, 32'h500, 0, 32'h0, 0, 0, 1, 0);
    apply_stimulus("flush",    1, 1, 0, 0, 32'h200, 1, 32'h200, 1, 1, 0, 1);
    apply_stimulus("recover1", 0, 0, 0, 1, 32'h600, 0, 32'h0, 0, 0, 0, 1);
    apply_stimulus("recover2", 0, 0, 0, 1, 32'h600, 0, 32'h0, 0, 0, 0, 1);
    apply_stimulus("rec_done", 0, 0, 0, 1, 32'h600, 1, 32'h600, 0, 0, 0, 0);
    check_counts("rec_done", 1, 2, 2);

    // Jump counter saturates at all-ones.
    for (int i = 0; i < 20; i++)
      apply_stimulus("sat_jump", 0, 0, 1, 0, 32'h1000 + 32'(i) * PC_INC,
                     1, 32'h1000 + 32'(i) * PC_INC, 1, 0, 0, 0);
    check_counts("saturate", 1, 15, 2);

    // Reset while holding a parked jump: nothing issues afterwards.
    apply_stimulus("hold_jump", 1, 0, 1, 0, 32'h700, 0, 32'h0, 0, 0, 1, 0);
    apply_stimulus("hold_wait", 1, 0, 0, 0, 32'h0,   0, 32'h0, 0, 0, 1, 1);
    reset = 1'b1;
    apply_stimulus("mid_reset", 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    reset = 1'b0;
    check_counts("mid_reset", 0, 0, 0);
    apply_stimulus("after_rst", 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    apply_stimulus("after_rst2",0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
